// File: rtl/aes_prng_masking_mc.sv
`default_nettype none
// ============================================================================
// Module   : aes_prng_masking_mc
// Purpose  : Multi-channel masking PRNG. Per-chunk Galois LFSRs followed by
//            a global bit permutation feed one-entry buffers, one per
//            consumer channel. A round-robin arbiter refills one buffer per
//            cycle. The generator is reseeded from EDN entropy, either on
//            request or after a programmable number of LFSR steps.
// Ports    : clk_i, rst_i        clock, synchronous active-high reset
//            data_req_i/ack_o   per-channel mask handshake, data_o words
//            reseed_req_i/ack_o explicit reseed request (level) / done pulse
//            entropy_req_o/ack_i/entropy_i  EDN entropy beats
//            busy_o             high while reseeding
//            err_o              pulse when an all-zero chunk seed is replaced
// Revision : 1.0 - initial release
// ============================================================================
module aes_prng_masking_mc #(
  parameter int unsigned             Width          = 64,
  parameter int unsigned             ChunkSize      = 32,
  parameter int unsigned             EntropyWidth   = 32,
  parameter int unsigned             NumChannels    = 2,
  parameter logic [15:0]             ReseedInterval = 16'd1024,
  parameter logic [Width-1:0]        DefaultSeed    = Width'(64'h5A5A_3C3C_0F0F_9696),
  // Entry b selects the state bit that drives output bit b.
  parameter logic [Width-1:0][7:0]   LfsrPerm       = {
    8'd63, 8'd62, 8'd61, 8'd60, 8'd59, 8'd58, 8'd57, 8'd56,
    8'd55, 8'd54, 8'd53, 8'd52, 8'd51, 8'd50, 8'd49, 8'd48,
    8'd47, 8'd46, 8'd45, 8'd44, 8'd43, 8'd42, 8'd41, 8'd40,
    8'd39, 8'd38, 8'd37, 8'd36, 8'd35, 8'd34, 8'd33, 8'd32,
    8'd31, 8'd30, 8'd29, 8'd28, 8'd27, 8'd26, 8'd25, 8'd24,
    8'd23, 8'd22, 8'd21, 8'd20, 8'd19, 8'd18, 8'd17, 8'd16,
    8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9,  8'd8,
    8'd7,  8'd6,  8'd5,  8'd4,  8'd3,  8'd2,  8'd1,  8'd0}
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumChannels-1:0]              data_req_i,
  output logic [NumChannels-1:0]              data_ack_o,
  output logic [NumChannels-1:0][Width-1:0]   data_o,
  input  logic                                reseed_req_i,
  output logic                                reseed_ack_o,
  output logic                                entropy_req_o,
  input  logic                                entropy_ack_i,
  input  logic [EntropyWidth-1:0]             entropy_i,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int unsigned NumChunks = Width / ChunkSize;
  localparam int unsigned NumBeats  = Width / EntropyWidth;
  localparam int unsigned BeatW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned PtrW      = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned PermIdxW  = $clog2(Width);

  // Right-shifting Galois feedback masks for maximal-length polynomials.
  localparam logic [63:0] MaskAll =
      (ChunkSize == 8)  ? 64'h0000_0000_0000_00B8 :
      (ChunkSize == 16) ? 64'h0000_0000_0000_D008 :
      (ChunkSize == 64) ? 64'hD800_0000_0000_0000 :
                          64'h0000_0000_8020_0003;
  localparam logic [ChunkSize-1:0] LfsrMask = MaskAll[ChunkSize-1:0];

  typedef enum logic [0:0] {StIdle = 1'b0, StReseed = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [Width-1:0]        lfsr_q;
  logic [Width-1:0]        buf_q [NumChannels];
  logic [NumChannels-1:0]  valid_q;
  logic [PtrW-1:0]         ptr_q;
  logic [15:0]             cnt_q;
  logic [BeatW-1:0]        beat_q;
  logic [Width-1:0]        stage_q;
  logic                    pend_q;
  logic                    reseed_ack_q;
  logic                    err_q;

  logic [Width-1:0]        perm;
  logic [Width-1:0]        lfsr_step;
  logic [Width-1:0]        seed_raw;
  logic [Width-1:0]        seed_load;
  logic [NumChunks-1:0]    chunk_zero;
  logic [NumChannels-1:0]  refill_empty;
  logic                    gnt_vld;
  logic [PtrW-1:0]         gnt_idx;
  logic [PtrW-1:0]         ptr_next;
  logic                    auto_trig;
  logic                    expl_req;
  logic                    last_beat;
  logic                    grant;

  for (genvar i = 0; i < NumChunks; i++) begin : g_chunk
    logic [ChunkSize-1:0] cur;
    logic [ChunkSize-1:0] raw;
    assign cur = lfsr_q[i*ChunkSize +: ChunkSize];
    assign raw = seed_raw[i*ChunkSize +: ChunkSize];
    assign lfsr_step[i*ChunkSize +: ChunkSize] =
        {1'b0, cur[ChunkSize-1:1]} ^ (cur[0] ? LfsrMask : '0);
    // An all-zero chunk would lock its LFSR, so fall back to the reset seed.
    assign chunk_zero[i] = (raw == '0);
    assign seed_load[i*ChunkSize +: ChunkSize] =
        chunk_zero[i] ? DefaultSeed[i*ChunkSize +: ChunkSize] : raw;
  end

  for (genvar b = 0; b < Width; b++) begin : g_perm
    assign perm[b] = lfsr_q[LfsrPerm[b][PermIdxW-1:0]];
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_out
    assign data_o[c] = buf_q[c];
  end

  assign data_ack_o    = data_req_i & valid_q;
  assign refill_empty  = ~valid_q | data_ack_o;
  assign entropy_req_o = (state_q == StReseed);
  assign busy_o        = (state_q == StReseed);
  assign reseed_ack_o  = reseed_ack_q;
  assign err_o         = err_q;

  assign auto_trig = (ReseedInterval != 16'd0) && (cnt_q == ReseedInterval);
  // The request is still high in the cycle its acknowledge is visible.
  assign expl_req  = reseed_req_i & ~reseed_ack_q;
  assign last_beat = (state_q == StReseed) && entropy_ack_i &&
                     (beat_q == BeatW'(NumBeats - 1));
  // Once the step budget is used up the LFSR must not advance further.
  assign grant     = (state_q == StIdle) && !auto_trig && gnt_vld;
  assign ptr_next  = (gnt_idx == PtrW'(NumChannels - 1)) ? '0 : gnt_idx + 1'b1;

  // Round-robin search starting at the pointer.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned j = 0; j < NumChannels; j++) begin
      idx = (32'(ptr_q) + j) % NumChannels;
      if (!gnt_vld && refill_empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PtrW'(idx);
      end
    end
  end

  // Staging value with the current beat merged in, so the final beat can be
  // loaded into the LFSRs on the same edge that it arrives.
  always_comb begin
    seed_raw = stage_q;
    for (int b = 0; b < NumBeats; b++) begin
      if (beat_q == BeatW'(b)) begin
        seed_raw[b*EntropyWidth +: EntropyWidth] = entropy_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (auto_trig || expl_req) state_d = StReseed;
      StReseed: if (last_beat) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      lfsr_q       <= DefaultSeed;
      valid_q      <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      beat_q       <= '0;
      stage_q      <= '0;
      pend_q       <= 1'b0;
      reseed_ack_q <= 1'b0;
      err_q        <= 1'b0;
      for (int c = 0; c < NumChannels; c++) buf_q[c] <= '0;
    end else begin
      state_q      <= state_d;
      reseed_ack_q <= 1'b0;
      err_q        <= 1'b0;
      valid_q      <= valid_q & ~data_ack_o;
      if (grant) begin
        buf_q[gnt_idx]   <= perm;
        valid_q[gnt_idx] <= 1'b1;
        lfsr_q           <= lfsr_step;
        ptr_q            <= ptr_next;
        if (cnt_q != ReseedInterval) cnt_q <= cnt_q + 16'd1;
      end
      if (state_q == StIdle && expl_req) pend_q <= 1'b1;
      if (state_q == StReseed) begin
        if (reseed_req_i) pend_q <= 1'b1;
        if (entropy_ack_i) begin
          stage_q <= seed_raw;
          if (last_beat) begin
            lfsr_q       <= seed_load;
            valid_q      <= '0;
            cnt_q        <= '0;
            beat_q       <= '0;
            err_q        <= |chunk_zero;
            reseed_ack_q <= pend_q | reseed_req_i;
            pend_q       <= 1'b0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_prng_masking_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_prng_masking_mc
// Purpose  : Self-checking bench for aes_prng_masking_mc (2 channels,
//            64-bit words, automatic reseed every 4 steps).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_prng_masking_mc;

  localparam int          NC    = 2;
  localparam int          NB    = 2;
  localparam logic [15:0] RI    = 16'd4;
  localparam logic [63:0] DSEED = 64'h5A5A_3C3C_0F0F_9696;
  localparam logic [31:0] POLY  = 32'h8020_0003;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [NC-1:0]          data_req_i;
  logic [NC-1:0]          data_ack_o;
  logic [NC-1:0][63:0]    data_o;
  logic                   reseed_req_i;
  logic                   reseed_ack_o;
  logic                   entropy_req_o;
  logic                   entropy_ack_i;
  logic [31:0]            entropy_i;
  logic                   busy_o;
  logic                   err_o;

  always #5 clk = ~clk;

  aes_prng_masking_mc #(.ReseedInterval(RI)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_ack_o(data_ack_o), .data_o(data_o),
    .reseed_req_i(reseed_req_i), .reseed_ack_o(reseed_ack_o),
    .entropy_req_o(entropy_req_o), .entropy_ack_i(entropy_ack_i),
    .entropy_i(entropy_i), .busy_o(busy_o), .err_o(err_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural reference state
  logic [63:0] m_state;
  logic [63:0] m_buf [NC];
  logic [NC-1:0] m_valid;
  int          m_ptr, m_cnt, m_k;
  bit          m_rs, m_pend, m_ackp, m_errp;
  logic [63:0] m_stage;

  typedef struct {
    logic [31:0] b0;
    logic [31:0] b1;
    logic [63:0] seed;
    logic        err;
  } rs_vec_t;
  rs_vec_t tbl [4];

  function automatic logic [63:0] next_state(input logic [63:0] s);
    logic [63:0] r;
    logic [31:0] c;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      c = s[32*i +: 32];
      r[32*i +: 32] = (c >> 1) ^ (c[0] ? POLY : 32'h0);
    end
    return r;
  endfunction

  task automatic model_update();
    logic [NC-1:0] ack, vb;
    bit            ackp, errp, trig, ex;
    int            g, c;
    if (rst_i) begin
      m_state = DSEED; m_valid = '0; m_ptr = 0; m_cnt = 0; m_k = 0;
      m_rs = 0; m_pend = 0; m_ackp = 0; m_errp = 0; m_stage = '0;
      for (int i = 0; i < NC; i++) m_buf[i] = '0;
      return;
    end
    ack = data_req_i & m_valid;
    vb = m_valid;
    m_valid = m_valid & ~ack;
    ackp = 0; errp = 0;
    if (!m_rs) begin
      trig = (RI != 0) && (m_cnt == int'(RI));
      ex = reseed_req_i && !m_ackp;
      g = -1;
      if (!trig) begin
        for (int j = 0; j < NC; j++) begin
          c = (m_ptr + j) % NC;
          if (g < 0 && (!vb[c] || ack[c])) g = c;
        end
      end
      if (g >= 0) begin
        m_buf[g] = m_state;
        m_valid[g] = 1'b1;
        m_state = next_state(m_state);
        if (m_cnt < int'(RI)) m_cnt++;
        m_ptr = (g + 1) % NC;
      end
      if (trig || ex) begin
        m_rs = 1;
        if (ex) m_pend = 1;
      end
    end else begin
      if (reseed_req_i) m_pend = 1;
      if (entropy_ack_i) begin
        m_stage[32*m_k +: 32] = entropy_i;
        if (m_k == NB - 1) begin
          for (int i = 0; i < 2; i++) begin
            if (m_stage[32*i +: 32] == 32'h0) begin
              m_stage[32*i +: 32] = DSEED[32*i +: 32];
              errp = 1;
            end
          end
          m_state = m_stage; m_valid = '0; m_cnt = 0; m_k = 0; m_rs = 0;
          ackp = m_pend; m_pend = 0;
        end else begin
          m_k++;
        end
      end
    end
    m_ackp = ackp;
    m_errp = errp;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cmp_model();
    chk("m_ack", 64'(data_ack_o), 64'(data_req_i & m_valid));
    for (int i = 0; i < NC; i++) chk("m_data", data_o[i], m_buf[i]);
    chk("m_entropy_req", 64'(entropy_req_o), 64'(m_rs));
    chk("m_busy", 64'(busy_o), 64'(m_rs));
    chk("m_reseed_ack", 64'(reseed_ack_o), 64'(m_ackp));
    chk("m_err", 64'(err_o), 64'(m_errp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    reseed_req_i = 1'b0;
    entropy_ack_i = 1'b0;
    tick();
    tick();
    chk("rst_ack", 64'(data_ack_o), 64'h0);
    chk("rst_data0", data_o[0], 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    rst_i = 1'b0;
  endtask

  int n_ereq, n_rack, waited;
  logic [63:0] seed;

  initial begin
    rst_i = 1'b1; data_req_i = '0; reseed_req_i = 1'b0;
    entropy_ack_i = 1'b0; entropy_i = '0;

    tbl[0] = '{32'hDEADBEEF, 32'h01234567, 64'h01234567_DEADBEEF, 1'b0};
    tbl[1] = '{32'h00000000, 32'h00000001, 64'h00000001_0F0F9696, 1'b1};
    tbl[2] = '{32'h00000000, 32'h00000000, 64'h5A5A3C3C_0F0F9696, 1'b1};
    tbl[3] = '{32'hAAAA5555, 32'h00000000, 64'h5A5A3C3C_AAAA5555, 1'b1};

    // Continuous requests from reset, then automatic reseed after 4 steps
    do_reset();
    data_req_i = 2'b11;
    tick(); chk("c1_ack", 64'(data_ack_o), 64'h1); chk("c1_w0", data_o[0], DSEED);
    tick(); chk("c2_ack", 64'(data_ack_o), 64'h2); chk("c2_w1", data_o[1], next_state(DSEED));
    tick(); chk("c3_w2", data_o[0], next_state(next_state(DSEED)));
    tick(); chk("c4_ereq", 64'(entropy_req_o), 64'h0);
    tick(); chk("c5_ereq", 64'(entropy_req_o), 64'h1); chk("c5_busy", 64'(busy_o), 64'h1);
    entropy_ack_i = 1'b1; entropy_i = 32'hDEADBEEF;
    tick();
    entropy_i = 32'h01234567;
    tick();
    entropy_ack_i = 1'b0;
    chk("auto_noack", 64'(reseed_ack_o), 64'h0);
    chk("auto_ereq_low", 64'(entropy_req_o), 64'h0);
    chk("auto_invalid", 64'(data_ack_o), 64'h0);
    seed = 64'h01234567_DEADBEEF;
    tick(); chk("auto_w0", data_o[0], seed);
    tick(); chk("auto_w1", data_o[1], next_state(seed));

    // Automatic trigger coincident with an explicit request
    waited = 0;
    while (!(m_cnt == int'(RI) && !m_rs) && waited < 20) begin
      tick(); waited++;
    end
    if (waited >= 20) begin
      n_chk++;
      $display("FAIL wait_auto: got timeout expected trigger");
    end
    reseed_req_i = 1'b1;
    entropy_ack_i = 1'b1;
    n_ereq = 0; n_rack = 0;
    for (int i = 0; i < 6; i++) begin
      entropy_i = $urandom;
      tick();
      if (entropy_req_o) n_ereq++;
      if (reseed_ack_o) begin n_rack++; reseed_req_i = 1'b0; end
    end
    entropy_ack_i = 1'b0;
    chk("merge_beats", 64'(n_ereq), 64'd2);
    chk("merge_acks", 64'(n_rack), 64'd1);

    // Reset in the middle of an explicit reseed
    do_reset();
    data_req_i = '0;
    reseed_req_i = 1'b1;
    tick();
    entropy_ack_i = 1'b1; entropy_i = 32'h12345678;
    tick();
    entropy_ack_i = 1'b0; reseed_req_i = 1'b0; rst_i = 1'b1;
    tick(); chk("abort_noack", 64'(reseed_ack_o), 64'h0);
    rst_i = 1'b0;
    tick(); tick();
    chk("abort_noack2", 64'(reseed_ack_o), 64'h0);
    chk("abort_w0", data_o[0], DSEED);

    // Table of explicit reseeds, buffers idle and full
    do_reset();
    data_req_i = '0;
    tick(); tick(); tick();
    for (int v = 0; v < 4; v++) begin
      reseed_req_i = 1'b1;
      tick();
      entropy_ack_i = 1'b1; entropy_i = tbl[v].b0;
      tick();
      entropy_i = tbl[v].b1;
      tick();
      entropy_ack_i = 1'b0; reseed_req_i = 1'b0;
      chk("tbl_ack", 64'(reseed_ack_o), 64'h1);
      chk("tbl_err", 64'(err_o), 64'(tbl[v].err));
      chk("tbl_ereq", 64'(entropy_req_o), 64'h0);
      tick(); tick();
      chk("tbl_seed", data_o[0], tbl[v].seed);
      chk("tbl_err_pulse", 64'(err_o), 64'h0);
    end

    // Randomised traffic against the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      data_req_i = NC'($urandom);
      if (reseed_req_i && reseed_ack_o) reseed_req_i = 1'b0;
      else if (!reseed_req_i && $urandom_range(0, 15) == 0) reseed_req_i = 1'b1;
      entropy_ack_i = ($urandom_range(0, 2) != 0);
      entropy_i = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rst_i = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_prng_masking_mc.md
# aes_prng_masking_mc

Multi-channel, parametrised pseudo-random generator that supplies masking data to several AES masking consumers in parallel. Each consumer gets its own buffered output with a request/acknowledge handshake. The generator is built from per-chunk Galois LFSRs followed by a global bit permutation. Reseeding packs entropy into a full seed and loads it atomically, rejects all-zero chunk seeds, and can trigger itself after a programmable number of LFSR steps. It sits between the EDN entropy interface and the cipher-core mask consumers.

## Interface
- Width, 64: PRNG output width; multiple of ChunkSize and of 8.
- ChunkSize, 32: width of each LFSR chunk; multiple of EntropyWidth.
- EntropyWidth, 32: width of one entropy beat.
- NumChannels, 2: number of consumer channels, 1..8.
- ReseedInterval, 16'd1024: LFSR steps between automatic reseeds; 0 disables automatic reseeding.
- DefaultSeed, Width'h5A5A_3C3C_0F0F_9696: reset seed, also the fallback seed for rejected chunks; no chunk of it is zero.
- LfsrPerm, identity: Width-entry bit permutation; perm_b[b] = state[LfsrPerm[b]].
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- data_req_i  in  NumChannels  per-channel request for a fresh mask word.
- data_ack_o  out  NumChannels  per-channel acknowledge; data_o[c] is valid while this is high.
- data_o  out  NumChannels x Width  per-channel mask word.
- reseed_req_i  in  1  explicit reseed request; level signal, held until acknowledged.
- reseed_ack_o  out  1  one-cycle pulse when an explicit reseed completes.
- entropy_req_o  out  1  entropy request to EDN.
- entropy_ack_i  in  1  entropy beat valid.
- entropy_i  in  EntropyWidth  entropy data.
- busy_o  out  1  high while the FSM is in RESEED.
- err_o  out  1  one-cycle pulse when one or more all-zero chunk seeds are rejected.

## Operation
**Generator**
- NumChunks = Width/ChunkSize Galois LFSRs. Each chunk has a full-period polynomial.
- perm = LfsrPerm applied across the full state vector.

**Buffers and refill**
- Each channel has a one-entry buffer with a valid flag, valid_q[c].
- data_ack_o[c] = data_req_i[c] & valid_q[c].
- data_o[c] = buf_q[c], regardless of the acknowledge.
- Refill happens only in state IDLE. Each cycle, a round-robin arbiter grants one channel whose buffer will be empty next cycle, i.e. !valid_q[c] or data_ack_o[c] in this cycle.
- On a grant:
  - buf_q[g] <= perm;
  - valid_q[g] <= 1;
  - LFSR steps once;
  - step counter increments;
  - the arbiter pointer moves to g+1 mod NumChannels.
- Consequence: no two channels ever receive the same state.
- Without a grant, the LFSR holds.

**FSM**
- IDLE -> RESEED when reseed_req_i is high or the step counter equals ReseedInterval (ReseedInterval != 0). A pending explicit request is latched as req_pend.
- RESEED:
  - entropy_req_o = 1.
  - Each entropy_ack_i writes entropy_i into the staging register at beat index k. Beat k=0 lands in the LSBs.
  - k runs 0..Width/EntropyWidth-1.
- On the last beat the whole staging value loads into the LFSRs in the same edge. Each chunk that is all-zero loads the corresponding DefaultSeed chunk instead, and err_o pulses in the next cycle.
- At the same edge:
  - all valid_q clear;
  - the step counter clears;
  - k clears;
  - FSM returns to IDLE;
  - if req_pend, reseed_ack_o pulses in the next cycle and req_pend clears.
- Consumers may still be acknowledged from already-valid buffers during RESEED, but no refill occurs.
- An automatic trigger and reseed_req_i arriving together, or reseed_req_i rising during an automatic reseed, are merged into one reseed, and that reseed is acknowledged.
- The step counter saturates at ReseedInterval.

## Timing
- Reset: LFSR state = DefaultSeed; all valid_q = 0; buf_q = 0; FSM = IDLE; counter, k, req_pend and arbiter pointer = 0. All outputs are 0 during reset.
- First cycle after reset: channel 0 is granted, and valid_q[0] = 1 one cycle later. Channel c is first valid c+1 cycles after reset.
- Refill latency: a buffer consumed in cycle t is valid again in t+1 if it is granted in t, otherwise in a later cycle. With all channels requesting continuously, each channel gets one word every NumChannels cycles.
- Reseed latency: the last entropy beat is in cycle t. In t+1: FSM = IDLE, reseed_ack_o = 1, err_o = 1 if a chunk was rejected, all valid_q = 0. The first post-reseed word is valid in t+2.
- entropy_ack_i while not in RESEED is ignored.
- rst_i asserted mid-reseed aborts the reseed: staging is discarded and no ack is given.

## Test plan
- Reset, then hold data_req_i = 2'b11 (NumChannels = 2) -> data_ack_o[0] at cycle 1, data_ack_o[1] at cycle 2. The words match a reference model started from DefaultSeed, in the order ch0, ch1, ch0, ch1, ...
- reseed_req_i = 1, entropy beats 32'hDEADBEEF then 32'h01234567 -> entropy_req_o falls after beat 2 and reseed_ack_o pulses once. State = 64'h01234567_DEADBEEF, buffers are invalid for one cycle, and the next words follow the model from the new seed.
- Reseed with beats 0, 32'h1 -> err_o pulses once; chunk 0 = DefaultSeed[31:0] and chunk 1 = 32'h1.
- ReseedInterval = 4 with continuous requests -> entropy_req_o rises after exactly 4 grants and busy_o = 1. After the 2 beats, reseed_ack_o stays 0.
- An automatic trigger coincident with reseed_req_i rising -> exactly one reseed (2 beats) and exactly one reseed_ack_o pulse.
- rst_i pulsed after the first entropy beat of a reseed -> no reseed_ack_o; output sequence restarts from DefaultSeed.
